// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-select codes,
// base opcodes and the shadow-slot record that tracks each in-flight instruction.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Slot register fields are sized for up to 256 registers; REG_AW must not exceed this.
  localparam int SLOT_AW = 8;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               we;
    logic               is_load;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic               use_rs1;
    logic               use_rs2;
  } slot_t;

  // A slot produces a value some reader needs; x0 never counts.
  function automatic logic raw_hit(slot_t w, logic use_src, logic [SLOT_AW-1:0] src);
    return w.valid && w.we && (w.rd != '0) && use_src && (w.rd == src);
  endfunction

endpackage

// File: rtl/mul_stall_timer.sv
// MUL occupancy timer: loads MUL_LAT-1 when a MUL enters EX and reports busy
// until the down-counter reaches its terminal count of zero.
module mul_stall_timer #(
  parameter int MUL_LAT = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam logic [3:0] LOAD_VAL = 4'(MUL_LAT - 1);

  logic [3:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipe: load-use/RAW stalls, MUL hold, redirect flush,
// operand forwarding (only when HAZ_FWD_EN is defined) and a stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              ex_redirect,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              hold_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              bubble_ex_mem,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  import riscv_pkg::*;

  slot_t              ex_q, mem_q, wb_q, id_slot;
  logic [SLOT_AW-1:0] id_rs1_w, id_rs2_w;
  logic               mul_busy, redirect, data_haz, issue;
  logic               slot_unused;

  assign id_rs1_w = SLOT_AW'(id_rs1);
  assign id_rs2_w = SLOT_AW'(id_rs2);

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = 1'b1;
    id_slot.rd      = SLOT_AW'(id_rd);
    id_slot.we      = id_we;
    id_slot.is_load = id_is_load;
    id_slot.rs1     = id_rs1_w;
    id_slot.rs2     = id_rs2_w;
    id_slot.use_rs1 = id_use_rs1;
    id_slot.use_rs2 = id_use_rs2;
  end

`ifdef HAZ_FWD_EN
  assign data_haz = id_valid && ex_q.is_load &&
                    (raw_hit(ex_q, id_use_rs1, id_rs1_w) || raw_hit(ex_q, id_use_rs2, id_rs2_w));

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (ex_q.valid) begin
      if (raw_hit(mem_q, ex_q.use_rs1, ex_q.rs1))     fwd_a_sel = FWD_MEM;
      else if (raw_hit(wb_q, ex_q.use_rs1, ex_q.rs1)) fwd_a_sel = FWD_WB;
      if (raw_hit(mem_q, ex_q.use_rs2, ex_q.rs2))     fwd_b_sel = FWD_MEM;
      else if (raw_hit(wb_q, ex_q.use_rs2, ex_q.rs2)) fwd_b_sel = FWD_WB;
    end
  end
`else
  // No bypass network: wait until the producer reaches WB (write-first regfile).
  assign data_haz = id_valid &&
                    (raw_hit(ex_q,  id_use_rs1, id_rs1_w) || raw_hit(ex_q,  id_use_rs2, id_rs2_w) ||
                     raw_hit(mem_q, id_use_rs1, id_rs1_w) || raw_hit(mem_q, id_use_rs2, id_rs2_w));
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

  // Not every slot field feeds logic in every build.
  assign slot_unused = ^{ex_q, mem_q, wb_q};

  mul_stall_timer #(.MUL_LAT(MUL_LAT)) u_mul_timer (
    .clock (clock),
    .reset (reset),
    .load  (issue && id_is_mul),
    .busy  (mul_busy)
  );

  // Redirect wins over a data stall but is ignored while a MUL holds EX.
  assign redirect      = ex_redirect && !mul_busy;
  assign stall_pc      = reset && (mul_busy || (data_haz && !redirect));
  assign stall_if_id   = stall_pc;
  assign hold_ex       = reset && mul_busy;
  assign bubble_ex_mem = hold_ex;
  assign flush_if_id   = reset && redirect;
  assign flush_id_ex   = reset && (redirect || (data_haz && !mul_busy));
  assign issue         = id_valid && !stall_pc && !flush_id_ex;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      wb_q <= mem_q;
      if (mul_busy) begin
        mem_q <= '0;
      end else begin
        mem_q <= ex_q;
        ex_q  <= issue ? id_slot : '0;
      end
      if (stall_pc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios with literal
// expectations plus randomized traffic against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 3;
  localparam int CW  = 4;
`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, id_is_mul, ex_redirect;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          stall_pc, stall_if_id, hold_ex, flush_if_id, flush_id_ex, bubble_ex_mem;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_AW(AW), .MUL_LAT(LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_redirect(ex_redirect),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .hold_ex(hold_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .bubble_ex_mem(bubble_ex_mem),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; int rd; bit we; bit ld; bit mul; int rs1; int rs2; bit u1; bit u2;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_age;  // cycles the current EX occupant has already spent in EX
  int   m_cnt;
  int   checks = 0;
  int   failures = 0;

  logic          obs_stall, obs_fii, obs_fie, obs_hold, obs_bub;
  logic [1:0]    obs_fa, obs_fb;
  logic [CW-1:0] obs_cnt;

  function automatic ins_t bubble();
    ins_t b;
    b = '{v:0, rd:0, we:0, ld:0, mul:0, rs1:0, rs2:0, u1:0, u2:0};
    return b;
  endfunction

  function automatic bit hit(ins_t w, bit u, int src);
    return w.v && w.we && (w.rd != 0) && u && (w.rd == src);
  endfunction

  function automatic int fwd_of(bit u, int src);
    if (!FWD || !m_ex.v || !u) return 0;
    if (hit(m_mem, 1'b1, src)) return 1;
    if (hit(m_wb, 1'b1, src))  return 2;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    m_age = 0; m_cnt = 0;
  endtask

  // Called just after a falling edge with inputs already applied: compare, then advance.
  task automatic step();
    ins_t idi;
    bit   busy, hl, hr, haz, redir, e_stall, e_fie, issue;
    #1;
    if (!reset) model_clear();
    idi = '{v:id_valid, rd:int'(id_rd), we:id_we, ld:id_is_load, mul:id_is_mul,
            rs1:int'(id_rs1), rs2:int'(id_rs2), u1:id_use_rs1, u2:id_use_rs2};
    busy = m_ex.v && m_ex.mul && (m_age < LAT - 1);
    hl = id_valid && m_ex.ld && (hit(m_ex, idi.u1, idi.rs1) || hit(m_ex, idi.u2, idi.rs2));
    hr = id_valid && (hit(m_ex, idi.u1, idi.rs1)  || hit(m_ex, idi.u2, idi.rs2) ||
                      hit(m_mem, idi.u1, idi.rs1) || hit(m_mem, idi.u2, idi.rs2));
    haz     = FWD ? hl : hr;
    redir   = reset && ex_redirect && !busy;
    e_stall = busy || (haz && !redir);
    e_fie   = redir || (haz && !busy);
    issue   = id_valid && !e_stall && !e_fie;

    obs_stall = stall_pc; obs_fii = flush_if_id; obs_fie = flush_id_ex;
    obs_hold = hold_ex; obs_bub = bubble_ex_mem; obs_fa = fwd_a_sel; obs_fb = fwd_b_sel;
    obs_cnt = stall_cnt;
    chk("stall_pc", stall_pc, int'(e_stall));
    chk("stall_if_id", stall_if_id, int'(e_stall));
    chk("hold_ex", hold_ex, int'(busy));
    chk("bubble_ex_mem", bubble_ex_mem, int'(busy));
    chk("flush_if_id", flush_if_id, int'(redir));
    chk("flush_id_ex", flush_id_ex, int'(e_fie));
    chk("fwd_a_sel", fwd_a_sel, fwd_of(m_ex.u1, m_ex.rs1));
    chk("fwd_b_sel", fwd_b_sel, fwd_of(m_ex.u2, m_ex.rs2));
    chk("stall_cnt", stall_cnt, m_cnt);

    @(posedge clock);
    if (!reset) begin
      model_clear();
    end else begin
      if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      m_wb = m_mem;
      if (busy) begin
        m_mem = bubble();
        m_age++;
      end else begin
        m_mem = m_ex;
        m_ex  = issue ? idi : bubble();
        m_age = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit we, input bit ld, input bit mul, input bit rdr);
    id_valid = v; id_rs1 = rs1[AW-1:0]; id_use_rs1 = u1; id_rs2 = rs2[AW-1:0]; id_use_rs2 = u2;
    id_rd = rd[AW-1:0]; id_we = we; id_is_load = ld; id_is_mul = mul; ex_redirect = rdr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    int nh, nb, r;
    model_clear();
    idle();
    @(negedge clock);
    step();
    chk("reset_cnt", obs_cnt, 0);
    chk("reset_stall", obs_stall, 0);

    // ADD x5 ; ADD x6,x5,x5
    do_reset();
    drv(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); step();
    drv(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); step();
`ifdef HAZ_FWD_EN
    chk("s1_no_stall", obs_stall, 0);
    idle(); step();
    chk("s1_fwd_a", obs_fa, 1);
    chk("s1_fwd_b", obs_fb, 1);
`else
    chk("s1_stall_ex", obs_stall, 1);
    step();
    chk("s1_stall_mem", obs_stall, 1);
    step();
    chk("s1_release", obs_stall, 0);
    idle(); step();
    chk("s1_fwd_a", obs_fa, 0);
    chk("s1_cnt", obs_cnt, 2);
`endif

    // LW x5 ; ADD x6,x5,x0
    do_reset();
    drv(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); step();
    drv(1, 5, 1, 0, 1, 6, 1, 0, 0, 0); step();
    chk("s2_stall", obs_stall, 1);
    chk("s2_flush_id_ex", obs_fie, 1);
`ifdef HAZ_FWD_EN
    step();
    chk("s2_release", obs_stall, 0);
    idle(); step();
    chk("s2_fwd_a", obs_fa, 2);
    chk("s2_fwd_b", obs_fb, 0);
    chk("s2_cnt", obs_cnt, 1);
`else
    step();
    chk("s2_stall_mem", obs_stall, 1);
    step();
    chk("s2_release", obs_stall, 0);
    idle(); step();
    chk("s2_fwd_a", obs_fa, 0);
    chk("s2_cnt", obs_cnt, 2);
`endif

    // MUL x5 with a 3-cycle EX occupancy
    do_reset();
    drv(1, 1, 1, 2, 1, 5, 1, 0, 1, 0); step();
    chk("s3_issue_no_hold", obs_hold, 0);
    idle();
    nh = 0; nb = 0;
    repeat (4) begin
      step();
      nh += int'(obs_hold);
      nb += int'(obs_bub);
    end
    chk("s3_hold_cycles", nh, 2);
    chk("s3_bubble_cycles", nb, 2);
    chk("s3_cnt", obs_cnt, 2);

    // redirect concurrent with load-use
    do_reset();
    drv(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); step();
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 1); step();
    chk("s4_flush_if_id", obs_fii, 1);
    chk("s4_flush_id_ex", obs_fie, 1);
    chk("s4_stall", obs_stall, 0);

    // writer of x0 then reader of x0
    do_reset();
    drv(1, 1, 1, 2, 1, 0, 1, 0, 0, 0); step();
    drv(1, 0, 1, 0, 1, 7, 1, 0, 0, 0); step();
    chk("s5_stall", obs_stall, 0);
    idle(); step();
    chk("s5_fwd_a", obs_fa, 0);
    chk("s5_fwd_b", obs_fb, 0);

    // reset in the middle of a MUL, with live inputs
    do_reset();
    drv(1, 1, 1, 2, 1, 5, 1, 0, 1, 0); step();
    idle(); step();
    chk("s6_busy", obs_hold, 1);
    reset = 1'b0;
    drv(1, 5, 1, 5, 1, 6, 1, 1, 0, 1);
    step();
    chk("s6_rst_hold", obs_hold, 0);
    chk("s6_rst_stall", obs_stall, 0);
    chk("s6_rst_flush_if_id", obs_fii, 0);
    chk("s6_rst_flush_id_ex", obs_fie, 0);
    chk("s6_rst_cnt", obs_cnt, 0);
    reset = 1'b1;
    idle(); step();
    chk("s6_mul_abandoned", obs_hold, 0);

    // randomized traffic on a small register set to provoke hazards
    repeat (3000) begin
      reset = ($urandom_range(0, 199) != 0);
      r = int'($urandom_range(0, 9));
      drv($urandom_range(0, 9) < 8,
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
          r < 2, r == 2, $urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register address width (32 architectural registers).
REQ-002 The block SHALL have parameter MUL_LAT, default 3, meaning EX-stage occupancy in cycles of a MUL (legal range 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-004 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- id_rd  in  REG_AW  ID destination.
- id_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is LW.
- id_is_mul  in  1  ID instruction is MUL.
- ex_redirect  in  1  EX resolved taken BGE/BLT or JAL.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID register.
- hold_ex  out  1  hold ID/EX register (MUL busy).
- flush_if_id  out  1  clear IF/ID register.
- flush_id_ex  out  1  load a bubble into ID/EX.
- bubble_ex_mem  out  1  load a bubble into EX/MEM.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- stall_cnt  out  CNT_W  cycles in which stall_pc was high.

Function
REQ-005 The block SHALL keep shadow slots EX, MEM and WB, each holding {valid, rd, we, is_load, rs1, rs2, use_rs1, use_rs2}, advancing ID->EX->MEM->WB each cycle unless held.
REQ-006 Issue SHALL occur when id_valid=1 and no stall/flush; otherwise a bubble (valid=0) enters the EX slot.
REQ-007 Load-use hazard: if the EX slot is a valid load with we=1, rd!=0, and rd matches a used ID source, stall_pc, stall_if_id and flush_id_ex SHALL be 1 for exactly one cycle.
REQ-008 Forwarding SHALL be combinational from the EX slot: select 01 if MEM slot valid, we=1, rd!=0, rd==source; else 10 for the same match on the WB slot; else 00. MEM has priority over WB.
REQ-009 Register x0 SHALL never cause a stall or a forward.
REQ-010 A MUL issued to EX SHALL load a down-counter with MUL_LAT-1; while the counter is nonzero, hold_ex, stall_pc and stall_if_id SHALL be 1, bubble_ex_mem SHALL be 1, and the EX slot SHALL hold; MUL_LAT=1 SHALL cause no stall.
REQ-011 On ex_redirect=1 with the counter at zero, flush_if_id and flush_id_ex SHALL be 1 in the same cycle; redirect SHALL override a concurrent load-use stall (stall outputs 0).
REQ-012 ex_redirect asserted while the MUL counter is nonzero SHALL be ignored.
REQ-013 stall_cnt SHALL increment once per cycle with stall_pc=1 and saturate at all-ones.

Reset
REQ-014 While reset=0, all slots SHALL be invalid, the MUL counter and stall_cnt SHALL be 0, and every output SHALL be 0; reset mid-MUL SHALL abandon the MUL.

Configuration
REQ-015 With HAZ_FWD_EN defined, forwarding SHALL follow REQ-008. Without it, fwd_a_sel and fwd_b_sel SHALL be tied to 00, and any RAW match against a valid writing EX or MEM slot SHALL stall as in REQ-007 until the writer reaches WB (regfile is write-first).

Structure
REQ-016 Package riscv_pkg SHALL hold the fwd_sel encodings, the opcode constants (R, I, LW, SW, BRANCH, JAL, AUIPC) and the slot struct typedef.
REQ-017 The MUL down-counter SHALL be a sub-module named mul_stall_timer.

Verification
REQ-018 The bench SHALL cover these scenarios:
- ADD x5 then ADD x6,x5,x5 back-to-back -> no stall; fwd_a_sel=fwd_b_sel=01 with the consumer in EX.
- LW x5 then ADD x6,x5,x0 -> one-cycle stall with flush_id_ex=1, then fwd_a_sel=10; stall_cnt=1.
- MUL x5 with MUL_LAT=3 -> hold_ex high for 2 cycles and bubble_ex_mem high for 2 cycles; stall_cnt=2.
- ex_redirect concurrent with a load-use hazard -> both flushes 1, stall_pc=0.
- Writer with rd=x0 followed by a reader of x0 -> fwd_sel=00, no stall.
- HAZ_FWD_EN undefined, ADD x5 then a reader of x5 -> 2 stall cycles, fwd_sel=00; reset=0 mid-MUL -> all outputs 0 immediately.
